// File: rtl/key_debouncer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared types and constants for the push-button debouncer.
//                Used by key_debounce_chan and key_debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    // Per-key debounce state.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } key_state_e;

    // Depth of the metastability synchroniser on each raw key pin.
    localparam int KEY_SYNC_STAGES = 2;

    // Bits needed to hold the values 0..max_val. Never returns less than 1.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_chan.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_chan
//  Description : One debounce channel: 2-flop synchroniser, 4-state debounce
//                FSM stepped by a shared sample tick, and registered level /
//                press / release outputs.
//                Optional auto-repeat of press pulses: KEY_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int            c_cnt_w = cnt_width(DEBOUNCE_TICKS);
    localparam logic [c_cnt_w-1:0] c_deb = c_cnt_w'(DEBOUNCE_TICKS);
    localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);

    logic [KEY_SYNC_STAGES-1:0] r_sync;
    key_state_e                 r_state;
    key_state_e                 w_state_nxt;
    logic [c_cnt_w-1:0]         r_cnt;
    logic [c_cnt_w-1:0]         w_cnt_nxt;
    logic [c_cnt_w-1:0]         w_cnt_inc;
    logic                       w_pressed;
    logic                       w_press_nxt;
    logic                       w_release_nxt;
    logic                       w_level_nxt;
    logic                       w_rep_fire;
    logic                       r_level;
    logic                       r_press;
    logic                       r_release;

    // Raw pin is asynchronous and active-low; resets to "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[KEY_SYNC_STAGES-2:0], i_key_n};
        end
    end

    assign w_pressed = ~r_sync[KEY_SYNC_STAGES-1];

    // Saturating stability counter increment.
    assign w_cnt_inc = (r_cnt >= c_deb) ? c_deb : r_cnt + 1'b1;

`ifdef KEY_AUTOREPEAT_EN
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_rep_w   = cnt_width(c_rep_max);
    localparam logic [c_rep_w-1:0] c_rep_delay = c_rep_w'(REPEAT_DELAY);
    localparam logic [c_rep_w-1:0] c_rep_rate  = c_rep_w'(REPEAT_RATE);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               r_rep_armed;
    logic [c_rep_w-1:0] w_rep_inc;
    logic [c_rep_w-1:0] w_rep_target;
    logic               w_rep_run;

    // Counter only advances on ticks that keep the key in PRESSED; it is
    // held through REL_WAIT so a bounce back to PRESSED resumes the period.
    assign w_rep_run    = i_tick && (r_state == PRESSED) && w_pressed;
    assign w_rep_inc    = r_rep_cnt + 1'b1;
    assign w_rep_target = r_rep_armed ? c_rep_rate : c_rep_delay;
    assign w_rep_fire   = w_rep_run && (w_rep_inc == w_rep_target);

    // Repeat period counter; cleared once the key is fully released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_state_nxt == IDLE) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b1;
        end else if (w_rep_run) begin
            r_rep_cnt   <= w_rep_inc;
        end
    end
`else
    logic w_unused_rep;

    assign w_rep_fire   = 1'b0;
    assign w_unused_rep = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

    // Debounce FSM state and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and pulse decode; the FSM only moves on a sample tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        if (i_tick) begin
            case (r_state)
                IDLE: begin
                    if (w_pressed) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            w_state_nxt = PRESSED;
                            w_cnt_nxt   = '0;
                            w_press_nxt = 1'b1;
                        end else begin
                            w_state_nxt = PRESS_WAIT;
                            w_cnt_nxt   = c_one;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!w_pressed) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == c_deb) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!w_pressed) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            w_state_nxt   = IDLE;
                            w_cnt_nxt     = '0;
                            w_release_nxt = 1'b1;
                        end else begin
                            w_state_nxt = REL_WAIT;
                            w_cnt_nxt   = c_one;
                        end
                    end else begin
                        w_press_nxt = w_rep_fire;
                    end
                end
                REL_WAIT: begin
                    if (w_pressed) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc == c_deb) begin
                        w_state_nxt   = IDLE;
                        w_cnt_nxt     = '0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt     = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
        w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == REL_WAIT);
    end

    // Registered outputs: pulses appear the clock after the accepting tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : key_debouncer
//  Description : Debounces NUM_KEYS raw active-low push-buttons. A shared
//                prescaler produces the sample tick; each key has its own
//                key_debounce_chan.
//                Optional auto-repeat of press pulses: KEY_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer
    import key_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] Key,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam int                 c_pre_w    = cnt_width(TICK_DIV - 1);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);

    logic [c_pre_w-1:0] r_pre;
    logic               w_tick;

    // With TICK_DIV=1 the count sits at 0 and the tick is permanently high.
    assign w_tick = (r_pre == c_pre_last);

    // Free-running sample prescaler, 0..TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            key_debounce_chan #(
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_RATE    (REPEAT_RATE)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_tick    (w_tick),
                .i_key_n   (Key[gi]),
                .o_level   (key_level[gi]),
                .o_press   (key_press[gi]),
                .o_release (key_release[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire
